// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side blocks: FSM state encoding and
// index-width helpers.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Width needed to index n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_last_owner,
// searching upward with wrap-around.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned OWN_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [OWN_W-1:0]   i_last_owner,
  output logic [OWN_W-1:0]   o_winner,
  output logic               o_any
);

  function automatic logic [OWN_W-1:0] wrap_idx(input logic [OWN_W-1:0] base,
                                                input int unsigned       off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_REQ;
    return OWN_W'(sum);
  endfunction

  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!o_any && i_req[wrap_idx(i_last_owner, k)]) begin
        o_winner = wrap_idx(i_last_owner, k);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ
// producers; grants one burst at a time, capped at MAX_BURST words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MAX_BURST  = 4,
  localparam int unsigned OWN_W      = idx_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          busy,
  output logic [OWN_W-1:0]              owner
);

  localparam int unsigned CNT_W = idx_width(MAX_BURST);

  arb_state_t       r_state;
  logic [OWN_W-1:0] r_owner;
  logic [OWN_W-1:0] r_last_owner;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_busy;

  logic [DATA_WIDTH-1:0] w_word [NUM_REQ];
  logic [OWN_W-1:0]      w_winner;
  logic                  w_any;
  logic                  w_accept;
  logic                  w_burst_end;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_word[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_rr_pick (
    .i_req        (req_valid),
    .i_last_owner (r_last_owner),
    .o_winner     (w_winner),
    .o_any        (w_any)
  );

  // Reset gates the write so an aborted burst never writes in the reset cycle.
  assign w_accept    = rst_n & (r_state == ST_BURST) & req_valid[r_owner] & ~full;
  assign w_burst_end = req_last[r_owner] | (r_beat_cnt == CNT_W'(MAX_BURST - 1));

  always_comb begin
    w_en      = w_accept;
    req_ready = '0;
    data_in   = '0;
    if (w_accept) begin
      req_ready[r_owner] = 1'b1;
      data_in            = w_word[r_owner];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= OWN_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner    <= w_winner;
            r_beat_cnt <= '0;
            r_state    <= ST_BURST;
            r_busy     <= 1'b1;
          end
        end
        ST_BURST: begin
          if (w_accept) begin
            if (w_burst_end) begin
              r_last_owner <= r_owner;
              r_beat_cnt   <= '0;
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign owner = r_owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter against a cycle-level
// reference model built from the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int OW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            full;
  logic            w_en;
  logic [DW-1:0]   data_in;
  logic            busy;
  logic [OW-1:0]   owner;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .full      (full),
    .w_en      (w_en),
    .data_in   (data_in),
    .busy      (busy),
    .owner     (owner)
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] d;
  } word_t;

  word_t src [N][$];
  bit    gap [N];
  int    seq [N];

  int fifo_log[$];
  int grant_log[$];
  int blen_log[$];
  int exp_q[$];
  int wr_count;
  bit busy_prev;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  bit m_busy;
  int m_owner;
  int m_last;
  int m_beats;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
    end
  endtask

  function automatic int rr_ref(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[OW'(idx)]) return idx;
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (src[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Queue a packet of n words for requester id; data encodes {id, sequence}.
  task automatic load(input int id, input int n);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.last = (k == n - 1);
      w.d    = DW'(id * 64 + seq[id] % 64);
      seq[id]++;
      src[id].push_back(w);
    end
  endtask

  task automatic push_exp(input int id, input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(id * 64 + (first + k) % 64);
  endtask

  task automatic clear_logs();
    fifo_log.delete();
    grant_log.delete();
    blen_log.delete();
    exp_q.delete();
    wr_count = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src[i].size() != 0) begin
        req_valid[i]           = !gap[i];
        req_data[i*DW +: DW]   = src[i][0].d;
        req_last[i]            = src[i][0].last;
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DW +: DW]   = '0;
        req_last[i]            = 1'b0;
      end
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model.
  task automatic cycle();
    logic         acc;
    logic [N-1:0] er;
    logic [DW-1:0] ed;
    int           w;
    @(negedge clk);
    drive();
    #1;
    acc = rst_n && m_busy && req_valid[OW'(m_owner)] && !full;
    er  = acc ? (N'(1) << m_owner) : '0;
    ed  = acc ? src[m_owner][0].d : '0;
    if (chk_en) begin
      chk("w_en", 32'(w_en), 32'(acc));
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("data_in", 32'(data_in), 32'(ed));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("owner", 32'(owner), 32'(m_owner));
    end
    if (w_en === 1'b1) begin
      fifo_log.push_back(int'(data_in));
      wr_count++;
    end
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_beats = 0;
    end else if (!m_busy) begin
      w = rr_ref(req_valid, m_last);
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_beats = 0;
      end
    end else if (acc) begin
      m_beats++;
      if (src[m_owner][0].last || m_beats == MB) begin
        m_last = m_owner;
        m_busy = 1'b0;
      end
      void'(src[m_owner].pop_front());
    end
    #1;
    if (busy === 1'b1 && !busy_prev) grant_log.push_back(int'(owner));
    if (busy !== 1'b1 && busy_prev) begin
      blen_log.push_back(wr_count);
      wr_count = 0;
    end
    busy_prev = (busy === 1'b1);
  endtask

  task automatic run_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, 32'(all_empty()), 32'd1);
    cycle();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int e[$];
    int cnt [N];
    int id;

    rst_n = 1'b0; full = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < N; i++) begin gap[i] = 1'b0; seq[i] = 0; end
    m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_beats = 0;
    busy_prev = 1'b0;
    clear_logs();

    // Reset held 3 cycles with everyone requesting, then round-robin 0,1,2,3,0.
    load(0, 2); load(1, 2); load(2, 2); load(3, 2); load(0, 2);
    cycle();
    chk_en = 1'b1;
    cycle(); cycle();
    chk("rst_wen", 32'(w_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("first_grant_busy", 32'(busy), 32'd1);
    chk("first_grant_owner", 32'(owner), 32'd0);
    run_empty("rr", 100);
    e = '{0, 1, 2, 3, 0};    chk_q("rr_grants", grant_log, e);
    e = '{2, 2, 2, 2, 2};    chk_q("rr_blen", blen_log, e);
    push_exp(0, 0, 2); push_exp(1, 0, 2); push_exp(2, 0, 2); push_exp(3, 0, 2); push_exp(0, 2, 2);
    chk_q("rr_fifo", fifo_log, exp_q);

    // Burst cap: six words from requester 2 split as 4 + 2.
    clear_logs();
    load(2, 6);
    run_empty("cap", 100);
    e = '{2, 2};  chk_q("cap_grants", grant_log, e);
    e = '{4, 2};  chk_q("cap_blen", blen_log, e);
    push_exp(2, 2, 6);
    chk_q("cap_fifo", fifo_log, exp_q);

    // Full stall in the middle of requester 1's burst.
    clear_logs();
    load(1, 4);
    cycle(); cycle();
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_wen", 32'(w_en), 32'd0);
      chk("stall_owner", 32'(owner), 32'd1);
    end
    full = 1'b0;
    run_empty("full", 100);
    e = '{1};  chk_q("full_grants", grant_log, e);
    e = '{4};  chk_q("full_blen", blen_log, e);
    push_exp(1, 2, 4);
    chk_q("full_fifo", fifo_log, exp_q);

    // Owner 3 drops valid for 2 cycles while 0 waits.
    clear_logs();
    load(3, 4); load(0, 2);
    cycle(); cycle();
    gap[3] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("gap_owner", 32'(owner), 32'd3);
      chk("gap_busy", 32'(busy), 32'd1);
    end
    gap[3] = 1'b0;
    run_empty("gap", 100);
    e = '{3, 0};  chk_q("gap_grants", grant_log, e);
    push_exp(3, 2, 4); push_exp(0, 4, 2);
    chk_q("gap_fifo", fifo_log, exp_q);

    // Reset after 2 of 4 words from requester 1; requester 0 wins afterwards.
    clear_logs();
    load(1, 4); load(0, 2);
    cycle(); cycle(); cycle();
    rst_n = 1'b0;
    cycle();
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_owner", 32'(owner), 32'd0);
    rst_n = 1'b1;
    run_empty("mrst", 100);
    e = '{1, 0, 1};  chk_q("mrst_grants", grant_log, e);
    push_exp(1, 6, 2); push_exp(0, 6, 2); push_exp(1, 8, 2);
    chk_q("mrst_fifo", fifo_log, exp_q);

    // Randomized traffic with random full and valid gaps.
    clear_logs();
    for (int i = 0; i < N; i++) begin
      cnt[i] = seq[i];
      for (int p = 0; p < 4; p++) load(i, int'($urandom_range(1, 6)));
    end
    begin
      int n;
      n = 0;
      while (!all_empty() && n < 3000) begin
        full = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < N; i++) gap[i] = ($urandom_range(0, 6) == 0);
        cycle();
        n++;
      end
    end
    full = 1'b0;
    for (int i = 0; i < N; i++) gap[i] = 1'b0;
    run_empty("rand", 100);
    foreach (fifo_log[j]) begin
      id = fifo_log[j] / 64;
      chk("rand_order", 32'(fifo_log[j]), 32'(id * 64 + cnt[id] % 64));
      cnt[id]++;
    end
    for (int i = 0; i < N; i++) chk($sformatf("rand_count%0d", i), 32'(cnt[i]), 32'(seq[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
